// File: rtl/instr_feeder.sv
// Program store + PC that feeds the 8-bit CPU one instruction per HOLD_CYCLES clocks.
// Optional INSTR_FEEDER_SINGLE_STEP_EN adds a step input gating RUN progress.
module instr_feeder #(
    parameter int                  INSTR_WIDTH = 20,
    parameter int                  PC_BITS     = 5,
    parameter int                  HOLD_CYCLES = 4,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_en,
    input  logic [PC_BITS-1:0]     load_addr,
    input  logic [INSTR_WIDTH-1:0] load_data,
    input  logic [PC_BITS:0]       prog_len,
    input  logic                   start,
    input  logic                   abort,
`ifdef INSTR_FEEDER_SINGLE_STEP_EN
    input  logic                   step,
`endif
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [PC_BITS-1:0]     pc,
    output logic                   busy,
    output logic                   done
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam int DEPTH = 2 ** PC_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [PC_BITS-1:0]     r_pc;
    logic [HW-1:0]          r_hold;
    logic [PC_BITS:0]       r_len;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [INSTR_WIDTH-1:0] r_mem [DEPTH];

    state_t                 w_state_nxt;
    logic [PC_BITS-1:0]     w_pc_nxt;
    logic [HW-1:0]          w_hold_nxt;
    logic [PC_BITS:0]       w_len_nxt;
    logic [INSTR_WIDTH-1:0] w_instr_nxt;
    logic [PC_BITS:0]       w_pc_inc;
    logic                   w_adv;

`ifdef INSTR_FEEDER_SINGLE_STEP_EN
    assign w_adv = step;
`else
    assign w_adv = 1'b1;
`endif

    // One bit wider than pc so a full-store program compares against len=2^PC_BITS
    assign w_pc_inc = {1'b0, r_pc} + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_hold_nxt  = r_hold;
        w_len_nxt   = r_len;
        w_instr_nxt = r_instr;
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_pc_nxt    = '0;
            w_hold_nxt  = '0;
            w_instr_nxt = NOP_INSTR;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (prog_len == '0) begin
                            w_state_nxt = S_DONE;
                            w_instr_nxt = NOP_INSTR;
                        end else begin
                            w_state_nxt = S_RUN;
                            w_pc_nxt    = '0;
                            w_hold_nxt  = '0;
                            w_len_nxt   = prog_len;
                            w_instr_nxt = r_mem[0];
                        end
                    end
                end
                S_RUN: begin
                    if (w_adv) begin
                        if (r_hold == HOLD_LAST) begin
                            w_hold_nxt = '0;
                            if (w_pc_inc == r_len) begin
                                w_state_nxt = S_DONE;
                                w_instr_nxt = NOP_INSTR;
                            end else begin
                                w_pc_nxt    = w_pc_inc[PC_BITS-1:0];
                                w_instr_nxt = r_mem[w_pc_inc[PC_BITS-1:0]];
                            end
                        end else begin
                            w_hold_nxt = r_hold + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_instr_nxt = NOP_INSTR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_hold  <= '0;
            r_len   <= '0;
            r_instr <= NOP_INSTR;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_hold  <= w_hold_nxt;
            r_len   <= w_len_nxt;
            r_instr <= w_instr_nxt;
        end
    end

    // Store survives reset; writes are locked out while a program is running
    always_ff @(posedge clk) begin
        if (load_en && r_state != S_RUN)
            r_mem[load_addr] <= load_data;
    end

`ifndef SYNTHESIS
    a_no_load_on_start: assert property (
        @(posedge clk) disable iff (!rst)
        !(start && load_en && !abort && r_state != S_RUN)
    );
`endif

    assign instruction = r_instr;
    assign pc          = r_pc;
    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);

endmodule
